// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the coordinate type used by the
// timing controller and the downstream video generator.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    // Half-open window test [lo, hi) on an unsigned 10-bit coordinate.
    function automatic logic in_range(input coord_t val, input int lo, input int hi);
        return (val >= coord_t'(lo)) && (val < coord_t'(hi));
    endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel clock-enable generator: one-clk pix_en strobe and a 50% duty vga_clk
// for the DAC, both registered from a wrapping divide-by-CLK_DIV counter.
module vga_pixel_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en_o,
    output logic vga_clk_o
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q, pix_en_d;
    logic          vga_clk_q, vga_clk_d;

    // Next divider count and the decodes that will be valid alongside it.
    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
        pix_en_d  = (div_d == DIV_LAST);
        vga_clk_d = (div_d >= DIV_HALF);
    end

    // Divider state and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pix_en_q  <= pix_en_d;
            vga_clk_q <= vga_clk_d;
        end
    end

    assign pix_en_o  = pix_en_q;
    assign vga_clk_o = vga_clk_q;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator (x/y counters, syncs, blanking, frame strobe).
// Optional macro VGA_SYNC_DELAY_EN delays hsync/vsync/blank_n by one pixel.
module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic   clk,
    input  logic   rst_n,
    output coord_t x,
    output coord_t y,
    output logic   hsync,
    output logic   vsync,
    output logic   blank_n,
    output logic   sync_n,
    output logic   vga_clk,
    output logic   pix_en,
    output logic   frame_start
);

    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;

    if ((H_TOT > 1024) || (V_TOT > 1024) || (CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_param_chk
        $error("vga_timing_controller: totals must be <= 1024 and CLK_DIV even and >= 2");
    end

    coord_t h_q, h_d, v_q, v_d, h_nxt_s, v_nxt_s;
    logic   h_wrap_s, pix_en_s, vga_clk_s;
    logic   hsync_q, hsync_d, vsync_q, vsync_d;
    logic   blank_n_q, blank_n_d, frame_start_q, frame_start_d;

    vga_pixel_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en_o  (pix_en_s),
        .vga_clk_o (vga_clk_s)
    );

    // Raster advance and decodes; decodes use the post-advance position so they line up with x/y.
    always_comb begin
        h_wrap_s = (h_q == coord_t'(H_TOT - 1));
        if (h_wrap_s) begin
            h_nxt_s = 10'd0;
            if (v_q == coord_t'(V_TOT - 1)) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = v_q + 10'd1;
            end
        end else begin
            h_nxt_s = h_q + 10'd1;
            v_nxt_s = v_q;
        end

        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_n_d     = blank_n_q;
        frame_start_d = 1'b0;
        if (pix_en_s) begin
            h_d           = h_nxt_s;
            v_d           = v_nxt_s;
            hsync_d       = !in_range(h_nxt_s, HS_BEG, HS_END);
            vsync_d       = !in_range(v_nxt_s, VS_BEG, VS_END);
            blank_n_d     = (h_nxt_s < coord_t'(H_ACTIVE)) && (v_nxt_s < coord_t'(V_ACTIVE));
            frame_start_d = (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // Raster position and decode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hsync_dly_q, vsync_dly_q, blank_n_dly_q;

    // One-pixel delay matching the generator's registered ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_dly_q   <= 1'b1;
            vsync_dly_q   <= 1'b1;
            blank_n_dly_q <= 1'b0;
        end else if (pix_en_s) begin
            hsync_dly_q   <= hsync_q;
            vsync_dly_q   <= vsync_q;
            blank_n_dly_q <= blank_n_q;
        end else begin
            hsync_dly_q   <= hsync_dly_q;
            vsync_dly_q   <= vsync_dly_q;
            blank_n_dly_q <= blank_n_dly_q;
        end
    end

    assign hsync   = hsync_dly_q;
    assign vsync   = vsync_dly_q;
    assign blank_n = blank_n_dly_q;
`else
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign blank_n = blank_n_q;
`endif

    assign x           = h_q;
    assign y           = v_q;
    assign sync_n      = 1'b0;
    assign vga_clk     = vga_clk_s;
    assign pix_en      = pix_en_s;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a default 640x480 instance and a shrunken
// raster instance (CLK_DIV=4) checked each cycle against an arithmetic model.
module tb_vga_timing_controller;

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    typedef struct {
        int x, y, hs, vs, bn, pe, vc, fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst0_n = 1'b0;
    logic       rst1_n = 1'b0;
    logic       chk_en = 1'b0;
    int         k0, k1;
    int         checks = 0;
    int         failures = 0;

    logic [9:0] x0, y0, x1, y1;
    logic       hs0, vs0, bn0, sn0, vc0, pe0, fs0;
    logic       hs1, vs1, bn1, sn1, vc1, pe1, fs1;

    always #10 clk = ~clk;

    vga_timing_controller dut0 (
        .clk(clk), .rst_n(rst0_n), .x(x0), .y(y0), .hsync(hs0), .vsync(vs0),
        .blank_n(bn0), .sync_n(sn0), .vga_clk(vc0), .pix_en(pe0), .frame_start(fs0)
    );

    vga_timing_controller #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n), .x(x1), .y(y1), .hsync(hs1), .vsync(vs1),
        .blank_n(bn1), .sync_n(sn1), .vga_clk(vc1), .pix_en(pe1), .frame_start(fs1)
    );

    // Clock edges since each instance left reset.
    always @(posedge clk or negedge rst0_n) begin
        if (!rst0_n) k0 <= 0;
        else         k0 <= k0 + 1;
    end

    always @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) k1 <= 0;
        else         k1 <= k1 + 1;
    end

    // Expected outputs after k clock edges since reset, from raster arithmetic.
    function automatic void model(input int k, input int cd, input int ha, input int hfp,
                                  input int hsw, input int hbp, input int va, input int vfp,
                                  input int vsw, input int vbp, output exp_t e);
        int ht, vt, p, ph, xh, yh;
        ht   = ha + hfp + hsw + hbp;
        vt   = va + vfp + vsw + vbp;
        p    = k / cd;
        e.x  = p % ht;
        e.y  = (p / ht) % vt;
        e.pe = int'((k % cd) == cd - 1);
        e.vc = int'((k % cd) >= cd / 2);
        e.fs = int'(p > 0 && (k % cd) == 0 && e.x == 0 && e.y == 0);
        ph   = p - DLY;
        if (ph < 1) begin
            e.hs = 1;
            e.vs = 1;
            e.bn = 0;
        end else begin
            xh   = ph % ht;
            yh   = (ph / ht) % vt;
            e.hs = int'(!(xh >= ha + hfp && xh < ha + hfp + hsw));
            e.vs = int'(!(yh >= va + vfp && yh < va + vfp + vsw));
            e.bn = int'(xh < ha && yh < va);
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string pfx, input exp_t e, input int x, input int y, input int hs,
                       input int vs, input int bn, input int sn, input int vc, input int pe,
                       input int fs);
        check({pfx, ".x"}, x, e.x);
        check({pfx, ".y"}, y, e.y);
        check({pfx, ".hsync"}, hs, e.hs);
        check({pfx, ".vsync"}, vs, e.vs);
        check({pfx, ".blank_n"}, bn, e.bn);
        check({pfx, ".sync_n"}, sn, 0);
        check({pfx, ".vga_clk"}, vc, e.vc);
        check({pfx, ".pix_en"}, pe, e.pe);
        check({pfx, ".frame_start"}, fs, e.fs);
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t e0, e1;
        if (chk_en) begin
            model(k0, 2, 640, 16, 96, 48, 480, 10, 2, 33, e0);
            cmp("dut0", e0, x0, y0, hs0, vs0, bn0, sn0, vc0, pe0, fs0);
            model(k1, 4, 16, 4, 6, 4, 12, 2, 2, 3, e1);
            cmp("dut1", e1, x1, y1, hs1, vs1, bn1, sn1, vc1, pe1, fs1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t m;
        int   cnt, cnt_fs, found;

        // Pin the model with hand-computed points of the 640x480 raster.
        model(1, 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.pe_k1", m.pe, 1);
        check("model.vc_k1", m.vc, 1);
        model(2 * (656 + DLY), 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.hs_start", m.hs, 0);
        model(2 * (655 + DLY), 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.hs_before", m.hs, 1);
        model(2 * (752 + DLY), 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.hs_end", m.hs, 1);
        model(2 * (640 + DLY), 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.bn_fall", m.bn, 0);
        model(2 * 800, 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.line_wrap_x", m.x, 0);
        check("model.line_wrap_y", m.y, 1);
        model(2 * (800 * 490 + DLY), 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.vs_start", m.vs, 0);
        model(2 * (800 * 492 + DLY), 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.vs_end", m.vs, 1);
        model(2 * 800 * 525, 2, 640, 16, 96, 48, 480, 10, 2, 33, m);
        check("model.frame_wrap_y", m.y, 0);
        check("model.frame_start", m.fs, 1);

        // Reset held, then released.
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst.x", x0, 0);
        check("rst.y", y0, 0);
        check("rst.hsync", hs0, 1);
        check("rst.vsync", vs0, 1);
        check("rst.blank_n", bn0, 0);
        check("rst.pix_en", pe0, 0);
        check("rst.vga_clk", vc0, 0);
        check("rst.frame_start", fs0, 0);
        chk_en = 1'b1;
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        @(negedge clk);
        check("first.pix_en", pe0, 1);
        check("first.vga_clk", vc0, 1);
        check("first.x", x0, 0);
        @(negedge clk);
        check("second.x", x0, 1);
        check("second.vga_clk", vc0, 0);
        check("second.blank_n", bn0, 1 - DLY);

        // One full line window: hsync low on exactly 96 pixels.
        cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (pe0 && !hs0) cnt++;
        end
        check("line.hsync_low_pixels", cnt, 96);

        // Small raster: one frame between two frame_start pulses.
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fs1) begin
                found = 1;
                break;
            end
        end
        check("dut1.first_frame_start", found, 1);
        cnt = 0;
        cnt_fs = 0;
        for (int i = 0; i < 2280; i++) begin
            @(negedge clk);
            if (fs1) cnt_fs++;
            if (pe1 && !vs1) cnt++;
        end
        check("dut1.frame_start_per_frame", cnt_fs, 1);
        check("dut1.vsync_low_pixels", cnt, 60);

        // Asynchronous reset mid-line on the default raster.
        for (int i = 0; i < 2000 && x0 != 10'd300; i++) @(negedge clk);
        check("dut0.reach_x300", x0, 300);
        #3 rst0_n = 1'b0;
        #1;
        check("arst0.x", x0, 0);
        check("arst0.y", y0, 0);
        check("arst0.hsync", hs0, 1);
        check("arst0.blank_n", bn0, 0);
        check("arst0.pix_en", pe0, 0);
        check("arst0.vga_clk", vc0, 0);
        check("arst0.frame_start", fs0, 0);
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst0.restart_x", x0, 2);
        check("arst0.restart_y", y0, 0);

        // Asynchronous reset mid-frame on the small raster, then a full wrap.
        for (int i = 0; i < 2500 && !(x1 == 10'd10 && y1 == 10'd7); i++) @(negedge clk);
        check("dut1.reach_x10", x1, 10);
        check("dut1.reach_y7", y1, 7);
        #3 rst1_n = 1'b0;
        #1;
        check("arst1.x", x1, 0);
        check("arst1.y", y1, 0);
        check("arst1.vsync", vs1, 1);
        check("arst1.frame_start", fs1, 0);
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        repeat (2400) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
